// File: rtl/pe_config_loader.sv
// Front end for the PE array: assembles 8-bit control words from a nibble stream
// into shadow registers, then holds the PEs enabled while it runs on them.
module pe_shadow_word (
    input  logic       clock,
    input  logic       reset,
    input  logic       we,
    input  logic [7:0] din,
    output logic [7:0] q
);
    always_ff @(posedge clock) begin
        if (reset)   q <= '0;
        else if (we) q <= din;
    end
endmodule

module pe_config_loader #(
    parameter int NUM_PE = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  cfg_valid,
    input  logic [3:0]            cfg_nibble,
    output logic                  cfg_ready,
    output logic [8*NUM_PE-1:0]   ctrl_bus,
    output logic                  pe_en,
    output logic                  loading,
    output logic [7:0]            run_count
);
    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx;
    logic                   ph;
    logic [3:0]             hi;
    logic                   hs, wr_word, clr;
    logic [NUM_PE-1:0][7:0] shadow;

    assign cfg_ready = (state == LOAD);
    assign loading   = cfg_ready;
    assign pe_en     = (state == RUN);
    assign ctrl_bus  = shadow;

    // halt takes priority over a nibble offered in the same cycle
    assign hs      = cfg_valid && cfg_ready && !halt;
    assign wr_word = hs && ph;
    assign clr     = (state != LOAD) && start && !halt;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && !halt) state_nxt = LOAD;
            LOAD: begin
                if (halt)                         state_nxt = IDLE;
                else if (wr_word && idx == LAST)  state_nxt = RUN;
            end
            RUN: begin
                if (halt)       state_nxt = IDLE;
                else if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx       <= '0;
            ph        <= 1'b0;
            hi        <= '0;
            run_count <= '0;
        end else if (clr) begin
            idx       <= '0;
            ph        <= 1'b0;
            run_count <= '0;
        end else begin
            if (hs) begin
                ph <= ~ph;
                if (!ph)              hi  <= cfg_nibble;
                else if (idx != LAST) idx <= idx + IDX_W'(1);
            end
            if (state == RUN && run_count != 8'hFF) run_count <= run_count + 8'd1;
        end
    end

    for (genvar i = 0; i < NUM_PE; i++) begin : g_word
        pe_shadow_word u_word (
            .clock (clock),
            .reset (reset),
            .we    (wr_word && idx == IDX_W'(i)),
            .din   ({hi, cfg_nibble}),
            .q     (shadow[i])
        );
    end
endmodule

// File: tb/tb_pe_config_loader.sv
// Randomized bench for pe_config_loader: a shadow-array model predicts ctrl_bus at each
// pe_en rise; a monitor pops the scoreboard and checks data and rise cycle.
module tb_pe_config_loader;
    localparam int NUM_PE = 4;

    logic                clock = 0, reset = 1, start = 0, halt = 0, cfg_valid = 0;
    logic [3:0]          cfg_nibble = 0;
    logic                cfg_ready, pe_en, loading;
    logic [8*NUM_PE-1:0] ctrl_bus;
    logic [7:0]          run_count;

    int          total = 0, bad = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [8*NUM_PE-1:0] data;
        int unsigned         cyc;
    } exp_t;
    exp_t sb[$];

    logic [7:0] mdl_sh [NUM_PE];
    logic       pe_en_q = 0;

    pe_config_loader #(.NUM_PE(NUM_PE)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .halt       (halt),
        .cfg_valid  (cfg_valid),
        .cfg_nibble (cfg_nibble),
        .cfg_ready  (cfg_ready),
        .ctrl_bus   (ctrl_bus),
        .pe_en      (pe_en),
        .loading    (loading),
        .run_count  (run_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [8*NUM_PE-1:0] mdl_bus();
        logic [8*NUM_PE-1:0] b;
        for (int j = 0; j < NUM_PE; j++) b[8*j +: 8] = mdl_sh[j];
        return b;
    endfunction

    // Scoreboard consumer: every pe_en rise must match the next expected load.
    always @(negedge clock) begin
        exp_t e;
        if (pe_en === 1'b1 && pe_en_q === 1'b0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pe_en_rise: unexpected rise at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("ctrl_bus_at_rise", ctrl_bus, e.data);
                check("rise_cycle", cyc, e.cyc);
            end
        end
        pe_en_q <= pe_en;
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_start();
        start = 1;
        step();
        start = 0;
        check("start_loading", loading, 1);
        check("start_ready", cfg_ready, 1);
        check("start_rc_clear", run_count, 0);
    endtask

    // Sends the first 'count' nibbles of 'words' (word i at bits [8i+7:8i], high nibble first).
    task automatic load(input logic [8*NUM_PE-1:0] words, input int count,
                        input bit stall, input int ign_at);
        for (int i = 0; i < count; i++) begin
            logic [3:0] nib;
            bit         acc;
            int         tries;
            nib   = i[0] ? words[8*(i/2) +: 4] : words[8*(i/2) + 4 +: 4];
            acc   = 0;
            tries = 0;
            while (!acc) begin
                check("load_ready", cfg_ready, 1);
                cfg_valid  = (!stall || tries >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                cfg_nibble = cfg_valid ? nib : 4'($urandom);
                start      = (i == ign_at) && (tries == 0);
                if (cfg_valid) begin
                    acc = 1;
                    if (i[0]) mdl_sh[i/2] = words[8*(i/2) +: 8];
                    if (i == 2*NUM_PE - 1) sb.push_back('{mdl_bus(), cyc + 1});
                end
                tries++;
                step();
            end
        end
        cfg_valid = 0;
        start     = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words;
        int          n;
        for (int j = 0; j < NUM_PE; j++) mdl_sh[j] = 8'h00;

        step(); step();
        reset = 0;
        check("rst_ctrl", ctrl_bus, 0);
        check("rst_pe_en", pe_en, 0);
        check("rst_ready", cfg_ready, 0);
        check("rst_loading", loading, 0);
        check("rst_rc", run_count, 0);

        // full-rate load
        do_start();
        load(32'h78563412, 8, 0, -1);
        repeat (10) step();
        check("rc_10", run_count, 10);

        // reset mid-RUN
        reset = 1;
        step();
        check("midrst_pe_en", pe_en, 0);
        check("midrst_ctrl", ctrl_bus, 0);
        step();
        reset = 0;
        for (int j = 0; j < NUM_PE; j++) mdl_sh[j] = 8'h00;
        check("midrst_ctrl2", ctrl_bus, 0);
        check("midrst_ready", cfg_ready, 0);
        check("midrst_rc", run_count, 0);

        // nibbles offered in IDLE are not consumed
        cfg_valid = 1;
        repeat (3) begin
            cfg_nibble = 4'($urandom);
            step();
        end
        cfg_valid = 0;
        check("idle_ctrl", ctrl_bus, 0);
        check("idle_loading", loading, 0);

        // stalled load
        do_start();
        load(32'h78563412, 8, 1, -1);
        repeat (3) step();
        check("rc_3", run_count, 3);

        // abort after A,B,C: word 0 kept, word 1 untouched
        do_start();
        load(32'h0000C0AB, 3, 1, -1);
        halt = 1;
        step();
        halt = 0;
        check("abort_pe_en", pe_en, 0);
        check("abort_loading", loading, 0);
        check("abort_ctrl", ctrl_bus, mdl_bus());
        check("abort_ctrl_const", ctrl_bus, 32'h785634AB);
        repeat (5) step();
        check("abort_pe_en_later", pe_en, 0);

        // random loads with an ignored mid-load start
        for (int r = 0; r < 6; r++) begin
            words = $urandom;
            do_start();
            load(words, 8, 1'($urandom_range(0, 1)), (r == 0) ? 3 : $urandom_range(1, 7));
            n = $urandom_range(1, 40);
            repeat (n) step();
            check("rand_rc", run_count, n);
            check("rand_ctrl", ctrl_bus, words);
        end

        // saturation, then halt+start together
        do_start();
        load($urandom, 8, 0, -1);
        repeat (300) step();
        check("rc_sat", run_count, 255);
        start = 1;
        halt  = 1;
        step();
        start = 0;
        halt  = 0;
        check("prio_pe_en", pe_en, 0);
        check("prio_loading", loading, 0);
        repeat (4) step();
        check("idle_rc_hold", run_count, 255);
        start = 1;
        halt  = 1;
        step();
        start = 0;
        halt  = 0;
        check("prio_idle_loading", loading, 0);

        // reconfigure with all-ones, then halt from RUN
        do_start();
        load(32'hFFFFFFFF, 8, 0, -1);
        repeat (2) step();
        check("ff_rc", run_count, 2);
        halt = 1;
        step();
        halt = 0;
        check("halt_pe_en", pe_en, 0);
        check("halt_rc", run_count, 3);
        repeat (3) step();
        check("halt_rc_hold", run_count, 3);
        check("halt_ctrl_hold", ctrl_bus, 32'hFFFFFFFF);

        repeat (3) step();
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pe_config_loader.md
# pe_config_loader

Configuration front end for the PE array. Accepts an 8-bit control word per PE as a stream of 4-bit nibbles over a valid/ready handshake, which fits the narrow pin budget. It holds the words in shadow registers that drive each PE's `ctrl_signals_in`, then raises the array enable so every PE latches its control word and starts computing. It sits directly upstream of the PEs and owns their `en` input.

## Interface
- `NUM_PE`, default 4: number of PEs configured; one 8-bit control word each.
- `clock` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a load sequence (IDLE or RUN).
- `halt` input 1: stop running or abort a load.
- `cfg_valid` input 1: nibble on `cfg_nibble` is valid.
- `cfg_nibble` input 4: configuration nibble, high nibble of each word first.
- `cfg_ready` output 1: loader accepts a nibble this cycle.
- `ctrl_bus` output 8*NUM_PE: word for PE i on bits [8i+7:8i], registered.
- `pe_en` output 1: enable to all PEs.
- `loading` output 1: state is LOAD.
- `run_count` output 8: cycles spent in RUN since the last load, saturating.

## Operation
- State register with three states: IDLE, LOAD, RUN.
- Datapath registers:
  - word index `idx`, 0..NUM_PE-1;
  - nibble phase `ph`: 0 = expecting high nibble, 1 = expecting low nibble;
  - high-nibble holding register `hi`;
  - shadow array `shadow[NUM_PE]` of 8-bit words;
  - `run_count`.
- A handshake is `cfg_valid && cfg_ready` at a rising edge. `cfg_ready` = (state == LOAD), a combinational decode of state.
- In LOAD, on handshake:
  - ph=0: `hi` <= nibble, ph <= 1.
  - ph=1: `shadow[idx]` <= {hi, nibble}, ph <= 0.
    - If idx == NUM_PE-1: state <= RUN.
    - Otherwise idx <= idx+1.
- Transitions:
  - IDLE --start--> LOAD: idx, ph, run_count cleared.
  - LOAD --final low nibble accepted--> RUN.
  - LOAD --halt--> IDLE: abort. A half-assembled word is discarded. Words already written keep their new values; `shadow` is never rolled back.
  - RUN --halt--> IDLE.
  - RUN --start (halt low)--> LOAD: reconfigure, with idx, ph, run_count cleared.
  - halt and start both high: halt wins in every state.
  - start while in LOAD is ignored; it does not restart the sequence.
- `cfg_valid` outside LOAD is ignored; no data is consumed.
- `pe_en` = (state == RUN), a decode of the state register. `ctrl_bus` is driven straight from `shadow`, so it is stable whenever `pe_en` is high.
- `run_count` increments by 1 each cycle that state == RUN, saturates at 255, and holds its value in IDLE.
- Reset values:
  - state IDLE, idx 0, ph 0, hi 0;
  - every shadow word 0, so `ctrl_bus` is 0;
  - pe_en 0, cfg_ready 0, loading 0, run_count 0.
- Reset mid-LOAD or mid-RUN forces all of the above on the next edge, including clearing `shadow`.

## Timing
- A full load takes 2*NUM_PE handshakes, with a minimum of 2*NUM_PE cycles at full throughput. Back-to-back handshakes every cycle must be accepted.
- When the final handshake occurs at edge k:
  - `ctrl_bus` shows all new words and `pe_en` = 1 in the cycle after edge k.
  - The PEs capture their control words at edge k+1.
- `start` sampled at edge k: `loading` and `cfg_ready` are 1 in cycle k+1. The first nibble can be accepted at edge k+1.
- `halt` sampled at edge k: `pe_en` is 0 in cycle k+1.
- RUN entered at edge k: `run_count` = 1 after edge k+1.
- `cfg_ready` has no combinational dependence on `cfg_valid`.

## Test plan
All scenarios use NUM_PE=4.
1. **Reset:** assert reset 2 cycles mid-RUN → next cycle state IDLE, `ctrl_bus`=32'h0, pe_en=0, cfg_ready=0, run_count=0.
2. **Full-rate load:** start, then nibbles 1,2,3,4,5,6,7,8 with valid high every cycle → ctrl_bus=32'h78563412; pe_en rises exactly one cycle after the 8th handshake; run_count=10 after 10 RUN cycles.
3. **Stalled load:** the same nibbles with cfg_valid toggling 1/0 → identical ctrl_bus. No nibble is consumed while valid=0, and none is consumed in IDLE before start.
4. **Abort:** start, send A,B,C, then assert halt → shadow[0]=8'hAB, shadow[1] unchanged (previous value), state IDLE, pe_en stays 0.
5. **Reconfigure and priority:** in RUN with run_count=300 cycles elapsed → run_count=255. Assert start and halt together → IDLE. Then start alone → LOAD with run_count=0; a new load of all 8'hFF gives ctrl_bus=32'hFFFFFFFF.
6. **Ignored start:** start pulsed mid-LOAD after 3 nibbles → load continues; idx/ph are not reset.
